// File: rtl/lcd_driver_pkg.sv
// Shared widths and 800x480 panel timing defaults for the LCD driver and the
// pattern generator, so both sides agree on the active area.
package lcd_driver_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned RGB_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  localparam cnt_t H_SYNC_DEF  = 11'd128;
  localparam cnt_t H_BACK_DEF  = 11'd88;
  localparam cnt_t H_DISP_DEF  = 11'd800;
  localparam cnt_t H_TOTAL_DEF = 11'd1056;
  localparam cnt_t V_SYNC_DEF  = 11'd2;
  localparam cnt_t V_BACK_DEF  = 11'd33;
  localparam cnt_t V_DISP_DEF  = 11'd480;
  localparam cnt_t V_TOTAL_DEF = 11'd525;

  // Half-open interval test [lo, hi) at full counter width.
  function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/lcd_timing_cnt.sv
// Horizontal/vertical position counter pair; v_cnt advances on the last
// pixel of each line and both wrap together at the end of the frame.
module lcd_timing_cnt
  import lcd_driver_pkg::*;
#(
  parameter cnt_t H_TOTAL = H_TOTAL_DEF,
  parameter cnt_t V_TOTAL = V_TOTAL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output cnt_t h_cnt,
  output cnt_t v_cnt
);

  localparam cnt_t H_LAST = CNT_W'(H_TOTAL - 11'd1);
  localparam cnt_t V_LAST = CNT_W'(V_TOTAL - 11'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 11'd1;
        end
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

endmodule

// File: rtl/lcd_driver.sv
// RGB565 parallel LCD timing driver: sync/DE decode, pixel request addressing
// one clock ahead of DE, panel reset release and backlight enable.
module lcd_driver
  import lcd_driver_pkg::*;
#(
  parameter cnt_t H_SYNC  = H_SYNC_DEF,
  parameter cnt_t H_BACK  = H_BACK_DEF,
  parameter cnt_t H_DISP  = H_DISP_DEF,
  parameter cnt_t H_TOTAL = H_TOTAL_DEF,
  parameter cnt_t V_SYNC  = V_SYNC_DEF,
  parameter cnt_t V_BACK  = V_BACK_DEF,
  parameter cnt_t V_DISP  = V_DISP_DEF,
  parameter cnt_t V_TOTAL = V_TOTAL_DEF
) (
  input  logic             lcd_clk,
  input  logic             sys_rst_n,
  input  logic [RGB_W-1:0] pixel_data,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [RGB_W-1:0] lcd_rgb,
  output logic             lcd_bl,
  output logic             lcd_rst,
  output logic             frame_start
);

  localparam cnt_t H_ACT     = CNT_W'(H_SYNC + H_BACK);
  localparam cnt_t H_END     = CNT_W'(H_ACT + H_DISP);
  localparam cnt_t H_REQ     = CNT_W'(H_ACT - 11'd1);
  localparam cnt_t H_REQ_END = CNT_W'(H_END - 11'd1);
  localparam cnt_t V_ACT     = CNT_W'(V_SYNC + V_BACK);
  localparam cnt_t V_END     = CNT_W'(V_ACT + V_DISP);

  cnt_t h_cnt;
  cnt_t v_cnt;
  logic bl_on;
  logic v_act;
  logic data_req;

  // Counters hold at the origin until the panel leaves reset, so the first
  // frame starts exactly one clock after release.
  lcd_timing_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_timing_cnt (
    .clk   (lcd_clk),
    .rst_n (sys_rst_n),
    .en    (lcd_rst),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt)
  );

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lcd_rst <= 1'b0;
    end else begin
      lcd_rst <= 1'b1;
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bl_on <= 1'b0;
    end else if (frame_start) begin
      bl_on <= 1'b1;
    end
  end

  // All panel outputs are decoded from the registered counters.
  always_comb begin
    v_act       = 1'b0;
    data_req    = 1'b0;
    lcd_hs      = 1'b0;
    lcd_vs      = 1'b0;
    lcd_de      = 1'b0;
    pixel_xpos  = '0;
    pixel_ypos  = '0;
    lcd_rgb     = '0;
    frame_start = 1'b0;
    lcd_bl      = 1'b0;

    v_act    = in_window(v_cnt, V_ACT, V_END);
    lcd_hs   = (h_cnt >= H_SYNC);
    lcd_vs   = (v_cnt >= V_SYNC);
    lcd_de   = v_act && in_window(h_cnt, H_ACT, H_END);
    data_req = v_act && in_window(h_cnt, H_REQ, H_REQ_END);
    if (data_req) begin
      pixel_xpos = h_cnt - H_REQ;
      pixel_ypos = v_cnt - V_ACT;
    end
    if (lcd_de) begin
      lcd_rgb = pixel_data;
    end
    frame_start = lcd_rst && (h_cnt == '0) && (v_cnt == '0);
    lcd_bl      = bl_on || frame_start;
  end

endmodule

// File: tb/tb_lcd_driver.sv
// Bench for lcd_driver on a reduced 10x5 panel: elapsed-time reference model,
// frame measurements and randomized asynchronous resets.
module tb_lcd_driver;

  localparam int unsigned HS = 4;
  localparam int unsigned HB = 3;
  localparam int unsigned HD = 10;
  localparam int unsigned HT = 20;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 2;
  localparam int unsigned VD = 5;
  localparam int unsigned VT = 12;
  localparam int unsigned FRAME = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] rgb;
    logic        bl;
    logic        rst;
    logic        fs;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] pixel_data;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [15:0] lcd_rgb;
  logic        lcd_bl;
  logic        lcd_rst;
  logic        frame_start;

  int          vectors;
  int          miscompares;
  int unsigned n;
  logic [15:0] salt;
  logic        chk_en;
  exp_t        cmp_e;

  lcd_driver #(
    .H_SYNC (11'(HS)), .H_BACK (11'(HB)), .H_DISP (11'(HD)), .H_TOTAL (11'(HT)),
    .V_SYNC (11'(VS)), .V_BACK (11'(VB)), .V_DISP (11'(VD)), .V_TOTAL (11'(VT))
  ) dut (
    .lcd_clk     (clk),
    .sys_rst_n   (rst_n),
    .pixel_data  (pixel_data),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_de      (lcd_de),
    .lcd_rgb     (lcd_rgb),
    .lcd_bl      (lcd_bl),
    .lcd_rst     (lcd_rst),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input int unsigned x, input int unsigned y,
                                      input logic [15:0] s);
    logic [10:0] xx;
    logic [4:0]  yy;
    xx = 11'(x);
    yy = 5'(y);
    return {yy, xx} ^ s;
  endfunction

  // Pattern generator: registers the pixel for the requested coordinates.
  always @(posedge clk) pixel_data <= pix(32'(pixel_xpos), 32'(pixel_ypos), salt);

  // Clock edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  // Raster position follows from elapsed time; the first edge after release
  // only lifts panel reset, so the origin is shown for one clock.
  function automatic exp_t model(input int unsigned cyc, input logic [15:0] s);
    exp_t        e;
    int unsigned p, h, v;
    logic        vin, req;
    p     = (cyc == 0) ? 0 : cyc - 1;
    h     = p % HT;
    v     = (p / HT) % VT;
    vin   = (v >= VS + VB) && (v < VS + VB + VD);
    req   = vin && (h >= HS + HB - 1) && (h < HS + HB + HD - 1);
    e.hs  = (h >= HS);
    e.vs  = (v >= VS);
    e.de  = vin && (h >= HS + HB) && (h < HS + HB + HD);
    e.x   = req ? 11'(h - (HS + HB - 1)) : 11'd0;
    e.y   = req ? 11'(v - (VS + VB)) : 11'd0;
    e.rgb = e.de ? pix(h - (HS + HB), v - (VS + VB), s) : 16'd0;
    e.rst = (cyc >= 1);
    e.fs  = (cyc >= 1) && (h == 0) && (v == 0);
    e.bl  = (cyc >= 1);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t n=%0d", name, act, exp, $time, n);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_e = model(n, salt);
      check("hs",    32'(lcd_hs),      32'(cmp_e.hs));
      check("vs",    32'(lcd_vs),      32'(cmp_e.vs));
      check("de",    32'(lcd_de),      32'(cmp_e.de));
      check("xpos",  32'(pixel_xpos),  32'(cmp_e.x));
      check("ypos",  32'(pixel_ypos),  32'(cmp_e.y));
      check("rgb",   32'(lcd_rgb),     32'(cmp_e.rgb));
      check("bl",    32'(lcd_bl),      32'(cmp_e.bl));
      check("rst",   32'(lcd_rst),     32'(cmp_e.rst));
      check("fs",    32'(frame_start), 32'(cmp_e.fs));
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_de"},   32'(lcd_de),      32'd0);
    check({tag, "_rgb"},  32'(lcd_rgb),     32'd0);
    check({tag, "_xpos"}, 32'(pixel_xpos),  32'd0);
    check({tag, "_ypos"}, 32'(pixel_ypos),  32'd0);
    check({tag, "_bl"},   32'(lcd_bl),      32'd0);
    check({tag, "_rst"},  32'(lcd_rst),     32'd0);
    check({tag, "_fs"},   32'(frame_start), 32'd0);
    check({tag, "_hs"},   32'(lcd_hs),      32'd0);
    check({tag, "_vs"},   32'(lcd_vs),      32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_rst_pre", 32'(lcd_rst), 32'd0);
    @(posedge clk);
    #1;
    check("rel_rst_post", 32'(lcd_rst),     32'd1);
    check("rel_fs",       32'(frame_start), 32'd1);
    check("rel_bl",       32'(lcd_bl),      32'd1);
  endtask

  // Asynchronous assertion a few ns after an edge, then a randomized release.
  task automatic pulse_reset();
    @(posedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    repeat ($urandom_range(1, 3)) @(posedge clk);
    salt = 16'($urandom);
    release_reset();
  endtask

  int hs_low, vs_low, de_cnt, first_de, run, max_run, de_lines, fs_extra;
  logic [VT-1:0] line_de;

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; salt = 16'd0; chk_en = 1'b0;
    hs_low = 0; vs_low = 0; de_cnt = 0; first_de = -1;
    run = 0; max_run = 0; de_lines = 0; fs_extra = 0; line_de = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    chk_en = 1'b1;
    release_reset();

    // One full frame from the first frame_start, plus the next frame_start.
    for (int i = 0; i <= int'(FRAME); i++) begin
      @(negedge clk);
      if (i < int'(FRAME)) begin
        if (!lcd_hs) hs_low++;
        if (!lcd_vs) vs_low++;
        if (i > 0 && frame_start) fs_extra++;
        if (lcd_de) begin
          de_cnt++;
          run++;
          if (run > max_run) max_run = run;
          if (first_de < 0) first_de = i;
          line_de[i / int'(HT)] = 1'b1;
        end else begin
          run = 0;
        end
      end
      if (i == 86) begin
        check("b_h6_xpos", 32'(pixel_xpos), 32'd0);
        check("b_h6_de",   32'(lcd_de),     32'd0);
      end
      if (i == 95) check("b_h15_xpos", 32'(pixel_xpos), 32'd9);
      if (i == 96) check("b_h16_xpos", 32'(pixel_xpos), 32'd0);
      if (i == 97) begin
        check("b_h17_de",  32'(lcd_de),  32'd0);
        check("b_h17_rgb", 32'(lcd_rgb), 32'd0);
      end
      if (i >= 87 && i <= 96) begin
        check("lat_de",  32'(lcd_de),  32'd1);
        check("lat_rgb", 32'(lcd_rgb), 32'(i - 87));
      end
      if (i == int'(FRAME) - 1) check("wrap_pre_fs", 32'(frame_start), 32'd0);
      if (i == int'(FRAME)) begin
        check("wrap_fs",   32'(frame_start), 32'd1);
        check("wrap_xpos", 32'(pixel_xpos),  32'd0);
      end
    end
    for (int l = 0; l < int'(VT); l++) if (line_de[l]) de_lines++;
    check("hs_low_cycles", 32'(hs_low),   32'd48);
    check("vs_low_cycles", 32'(vs_low),   32'd40);
    check("de_cycles",     32'(de_cnt),   32'd50);
    check("de_first",      32'(first_de), 32'd87);
    check("de_run",        32'(max_run),  32'd10);
    check("de_lines",      32'(de_lines), 32'd5);
    check("fs_extra",      32'(fs_extra), 32'd0);

    // Mid-frame reset while DE is active (line 7, pixel 10).
    for (int k = 0; k < int'(FRAME) + 2; k++) begin
      if (((n - 1) % FRAME) == 150) break;
      @(negedge clk);
    end
    check("mid_de_before", 32'(lcd_de), 32'd1);
    pulse_reset();

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(30, 700)) @(posedge clk);
      pulse_reset();
    end
    repeat (FRAME + 5) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
